// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MEM stage of the MIPS pipeline.
// Serves one load or store at a time from a local word array with a fixed
// multi-cycle latency, freezing the pipeline while the access is in flight.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   LATENCY      stall cycles per access, including the request cycle (1..16)
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   mem_read, mem_write     request strobes from EX/MEM (write wins if both)
//   addr, write_data        byte address and store data
//   read_data               registered load result, held until the next read
//   mem_stall               combinational pipeline freeze
//   mem_done                one-cycle completion pulse (registered)
//   misaligned              pulse with mem_done for an aborted misaligned access
// Build option:
//   DMEM_MISALIGN_CHECK_EN  when defined, accesses with addr[1:0] != 0 are
//                           aborted (no memory/read_data update) and flagged.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mem_stall,
  output logic        mem_done,
  output logic        misaligned
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  // Keep the counter at least one bit wide so LATENCY==1 still elaborates.
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = (LATENCY > 1) ? CntW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        lo_q, lo_d;
  logic [31:0]       read_data_q, read_data_d;
  logic              done_q, done_d;
  logic              mis_q, mis_d;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              req;
  logic              acc_en;
  logic              acc_wr;
  logic [IdxW-1:0]   acc_idx;
  logic [31:0]       acc_wdata;
  logic [1:0]        acc_lo;
  logic              acc_mis;
  logic              mem_we;
  logic              rd_en;

  assign req = mem_read | mem_write;

  // Access fields come from the live inputs when LATENCY==1 (access happens at
  // the request edge), otherwise from the latched copies.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    lo_d      = lo_q;
    acc_en    = 1'b0;
    acc_wr    = wr_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_lo    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          wr_d    = mem_write;
          idx_d   = addr[IdxW+1:2];
          wdata_d = write_data;
          lo_d    = addr[1:0];
          if (LATENCY == 1) begin
            acc_en    = 1'b1;
            acc_wr    = mem_write;
            acc_idx   = addr[IdxW+1:2];
            acc_wdata = write_data;
            acc_lo    = addr[1:0];
            state_d   = StDone;
          end else begin
            cnt_d   = CntLoad;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          acc_en  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        // Requests seen here belong to the completing instruction.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign acc_mis = |acc_lo;
`else
  assign acc_mis = 1'b0;
  logic unused_lo;
  assign unused_lo = ^acc_lo;
`endif

  logic unused_addr;
  assign unused_addr = ^addr[31:IdxW+2];

  // rst_n gate stops a LATENCY==1 write from landing while reset is held.
  assign mem_we = acc_en & acc_wr & ~acc_mis & rst_n;
  assign rd_en  = acc_en & ~acc_wr & ~acc_mis;

  always_comb begin
    read_data_d = rd_en ? mem[acc_idx] : read_data_q;
    done_d      = acc_en;
    mis_d       = acc_en & acc_mis;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      read_data_q <= '0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      read_data_q <= read_data_d;
      done_q      <= done_d;
      mis_q       <= mis_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign mem_stall  = ((state_q == StIdle) & req) | (state_q == StBusy);
  assign read_data  = read_data_q;
  assign mem_done   = done_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 uses LATENCY=2, instance 1 LATENCY=1.
// Stimulus pushes the expected completion into a per-instance queue; the
// monitor pops and compares on every mem_done pulse.
module tb_dmem_responder;

  typedef struct packed {
    logic [31:0] rd;
    logic        mis;
    logic        care;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read   [2];
  logic        mem_write  [2];
  logic [31:0] addr       [2];
  logic [31:0] write_data [2];
  logic [31:0] read_data  [2];
  logic        mem_stall  [2];
  logic        mem_done   [2];
  logic        misaligned [2];

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   issued   [2];
  int   done_cnt [2];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read[0]),
    .mem_write  (mem_write[0]),
    .addr       (addr[0]),
    .write_data (write_data[0]),
    .read_data  (read_data[0]),
    .mem_stall  (mem_stall[0]),
    .mem_done   (mem_done[0]),
    .misaligned (misaligned[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read[1]),
    .mem_write  (mem_write[1]),
    .addr       (addr[1]),
    .write_data (write_data[1]),
    .read_data  (read_data[1]),
    .mem_stall  (mem_stall[1]),
    .mem_done   (mem_done[1]),
    .misaligned (misaligned[1])
  );

  function automatic exp_t mk(input logic [31:0] rd, input logic mis);
    exp_t e;
    e.rd   = rd;
    e.mis  = mis;
    e.care = 1'b1;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic push(input int u, input exp_t e);
    issued[u]++;
    if (u == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  // Counts stall cycles until mem_done, checks the pulse is one cycle wide,
  // then drops the request.
  task automatic wait_done(input int u, input int lat);
    int  stalls = 0;
    bit  seen   = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mem_done[u]) seen = 1;
      else if (mem_stall[u]) stalls++;
    end
    check($sformatf("done_seen[%0d]", u), 32'(seen), 32'd1);
    check($sformatf("stall_cycles[%0d]", u), stalls, lat);
    @(posedge clk);
    #1;
    mem_read[u]  = 1'b0;
    mem_write[u] = 1'b0;
    @(negedge clk);
    check($sformatf("done_pulse_width[%0d]", u), 32'(mem_done[u]), 32'd0);
  endtask

  task automatic issue(input int u, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    mem_read[u]   = rd;
    mem_write[u]  = wr;
    addr[u]       = a;
    write_data[u] = d;
  endtask

  task automatic access(input int u, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input exp_t e, input int lat);
    issue(u, rd, wr, a, d);
    push(u, e);
    wait_done(u, lat);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int u = 0; u < 2; u++) begin
        if (mem_done[u]) begin
          done_cnt[u]++;
          if ((u == 0 && sb0.size() == 0) || (u == 1 && sb1.size() == 0)) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done[%0d]: got a pulse, expected none", u);
          end else begin
            if (u == 0) mon_e = sb0.pop_front();
            else        mon_e = sb1.pop_front();
            if (mon_e.care) begin
              n_cmp++;
              if (read_data[u] !== mon_e.rd || misaligned[u] !== mon_e.mis) begin
                n_err++;
                $display("FAIL completion[%0d]: got rd=0x%08h mis=%0b, expected rd=0x%08h mis=%0b",
                         u, read_data[u], misaligned[u], mon_e.rd, mon_e.mis);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    exp_t dc;
    dc = '0;
    for (int u = 0; u < 2; u++) begin
      mem_read[u]   = 1'b0;
      mem_write[u]  = 1'b0;
      addr[u]       = '0;
      write_data[u] = '0;
      issued[u]     = 0;
      done_cnt[u]   = 0;
    end
    rst_n       = 1'b0;
    mem_read[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_read_data", read_data[0], 32'h0);
    check("reset_done", 32'(mem_done[0]), 32'd0);
    check("reset_misaligned", 32'(misaligned[0]), 32'd0);

    // Release with mem_read already high: stall in the release cycle.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(0, dc);
    wait_done(0, 2);
    // Clear read_data back to a known 0.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;

    access(0, 0, 1, 32'h10,  32'hDEADBEEF, mk(32'h0,        1'b0), 2);
    access(0, 1, 0, 32'h10,  32'h0,        mk(32'hDEADBEEF, 1'b0), 2);
    access(0, 0, 1, 32'h400, 32'hA5A5A5A5, mk(32'hDEADBEEF, 1'b0), 2);
    access(0, 1, 0, 32'h0,   32'h0,        mk(32'hA5A5A5A5, 1'b0), 2);
    access(0, 0, 1, 32'h4,   32'h77,       mk(32'hA5A5A5A5, 1'b0), 2);
    access(0, 1, 1, 32'h8,   32'h5,        mk(32'hA5A5A5A5, 1'b0), 2);
    access(0, 1, 0, 32'h8,   32'h0,        mk(32'h5,        1'b0), 2);
    access(0, 0, 1, 32'h20,  32'h11111111, mk(32'h5,        1'b0), 2);

    // Store abandoned by reset while in BUSY.
    issue(0, 0, 1, 32'h20, 32'hFFFFFFFF);
    @(negedge clk);
    check("abort_stall_req_cycle", 32'(mem_stall[0]), 32'd1);
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    mem_write[0] = 1'b0;
    #1;
    check("abort_read_data", read_data[0], 32'h0);
    check("abort_done", 32'(mem_done[0]), 32'd0);
    check("abort_stall", 32'(mem_stall[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    access(0, 1, 0, 32'h20,  32'h0,        mk(32'h11111111, 1'b0), 2);
    access(0, 1, 0, 32'h4,   32'h0,        mk(32'h77,       1'b0), 2);
`ifdef DMEM_MISALIGN_CHECK_EN
    access(0, 1, 0, 32'h22,  32'h0,        mk(32'h77,       1'b1), 2);
`else
    access(0, 1, 0, 32'h22,  32'h0,        mk(32'h11111111, 1'b0), 2);
`endif

    // LATENCY=1 instance.
    access(1, 0, 1, 32'h0,   32'h12345678, mk(32'h0,        1'b0), 1);
    access(1, 1, 0, 32'h0,   32'h0,        mk(32'h12345678, 1'b0), 1);

    repeat (3) @(negedge clk);
    check("sb0_drained", sb0.size(), 32'd0);
    check("sb1_drained", sb1.size(), 32'd0);
    check("done_count_a", done_cnt[0], issued[0]);
    check("done_count_b", done_cnt[1], issued[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
